// File: rtl/strait_pkg.sv
// strait_pkg: definitions shared by the activation feeder slice.
//   - ST_* : feeder FSM state encodings, and the enum built from them.
//   - DEFAULT_SYSTOLIC_SIZE / DEFAULT_ACTIVATION_WIDTH : array geometry that
//     must agree with the downstream skew buffer.
package strait_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    STREAM = ST_STREAM,
    DRAIN  = ST_DRAIN,
    DONE   = ST_DONE
  } feeder_state_e;

  localparam int DEFAULT_SYSTOLIC_SIZE    = 8;
  localparam int DEFAULT_ACTIVATION_WIDTH = 8;

endpackage

// File: rtl/activation_feeder_if.sv
// activation_feeder_if: load port, control and stream port of the feeder.
//   load_valid/load_ready/load_data_flat : tile load handshake
//   start, test_mode                     : tile launch and mode select
//   replay                               : relaunch of the retained tile
//                                          (only with ACT_FEEDER_REPLAY_EN)
//   activation_out_flat/activation_valid : vector stream to the skew buffer
//   mode_out, busy, done                 : status
// Modports: master = host that loads and launches tiles, slave = the feeder.
interface activation_feeder_if
  import strait_pkg::*;
#(
  parameter int SYSTOLIC_SIZE    = DEFAULT_SYSTOLIC_SIZE,
  parameter int ACTIVATION_WIDTH = DEFAULT_ACTIVATION_WIDTH
);
  localparam int VEC_W = SYSTOLIC_SIZE * ACTIVATION_WIDTH;

  logic             load_valid;
  logic             load_ready;
  logic [VEC_W-1:0] load_data_flat;
  logic             start;
  logic             test_mode;
`ifdef ACT_FEEDER_REPLAY_EN
  logic             replay;
`endif
  logic [VEC_W-1:0] activation_out_flat;
  logic             activation_valid;
  logic             mode_out;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_data_flat, start, test_mode,
`ifdef ACT_FEEDER_REPLAY_EN
    output replay,
`endif
    input  load_ready, activation_out_flat, activation_valid, mode_out, busy, done
  );

  modport slave (
    input  load_valid, load_data_flat, start, test_mode,
`ifdef ACT_FEEDER_REPLAY_EN
    input  replay,
`endif
    output load_ready, activation_out_flat, activation_valid, mode_out, busy, done
  );

endinterface

// File: rtl/act_tile_regfile.sv
// act_tile_regfile: storage for one activation tile.
//   clk      : clock
//   wr_en    : write strobe, wr_data stored at wr_addr on the rising edge
//   wr_addr  : write index
//   wr_data  : flat vector to store
//   rd_addr  : read index
//   rd_data  : combinational read of entry rd_addr
// The array has no reset; validity is tracked by the owner's vector count.
module act_tile_regfile #(
  parameter int TILE_DEPTH = 16,
  parameter int VEC_W      = 64
) (
  input  logic                          clk,
  input  logic                          wr_en,
  input  logic [$clog2(TILE_DEPTH)-1:0] wr_addr,
  input  logic [VEC_W-1:0]              wr_data,
  input  logic [$clog2(TILE_DEPTH)-1:0] rd_addr,
  output logic [VEC_W-1:0]              rd_data
);

  logic [VEC_W-1:0] mem [TILE_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/activation_feeder.sv
// activation_feeder: collects one activation tile through a valid/ready load
// port and streams it, one vector per cycle, into the skew buffer. Normal mode
// appends SYSTOLIC_SIZE-1 zero vectors so the skewed lanes drain; test mode
// streams the tile only.
//   clk, rst : clock, synchronous active-high reset
//   bus      : activation_feeder_if.slave (load port, start/test_mode,
//              vector stream, mode_out, busy, done)
// Optional feature macro ACT_FEEDER_REPLAY_EN: keeps the tile after DONE and
// adds the replay input to stream it again without reloading.
module activation_feeder
  import strait_pkg::*;
#(
  parameter int SYSTOLIC_SIZE    = DEFAULT_SYSTOLIC_SIZE,
  parameter int ACTIVATION_WIDTH = DEFAULT_ACTIVATION_WIDTH,
  parameter int TILE_DEPTH       = 16
) (
  input logic                clk,
  input logic                rst,
  activation_feeder_if.slave bus
);

  localparam int VEC_W     = SYSTOLIC_SIZE * ACTIVATION_WIDTH;
  localparam int CNT_W     = $clog2(TILE_DEPTH + 1);
  localparam int PTR_W     = $clog2(TILE_DEPTH);
  localparam int DRAIN_LEN = SYSTOLIC_SIZE - 1;
  localparam int DRN_W     = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(TILE_DEPTH);
  localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'((DRAIN_LEN > 0) ? DRAIN_LEN - 1 : 0);

  feeder_state_e    state_q, state_d;
  logic [CNT_W-1:0] count_q, count_base, count_next;
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr;
  logic [DRN_W-1:0] drain_q;
  logic             mode_q;
  logic             busy_p1, done_p1;
  logic             vld_p1;
  logic [VEC_W-1:0] act_p1;
  logic [VEC_W-1:0] rd_data;
  logic             load_open, load_ready, load_fire, start_req, accept, last_rd;

`ifdef ACT_FEEDER_REPLAY_EN
  logic retained_q;

  // A retained tile counts as empty for loading: the first new vector goes to 0.
  assign count_base = retained_q ? '0 : count_q;
  assign start_req  = bus.start | bus.replay;
`else
  assign count_base = count_q;
  assign start_req  = bus.start;
`endif

  // The done cycle still belongs to the tile, so loading and launch wait one more cycle.
  assign load_open  = (state_q == IDLE) && !done_p1;
  assign load_ready = load_open && (count_base < DEPTH_C);
  assign load_fire  = bus.load_valid && load_ready;
  assign wr_ptr     = PTR_W'(count_base);
  assign count_next = load_fire ? (count_base + CNT_W'(1)) : count_q;
  assign accept     = load_open && start_req && (count_next != '0);
  assign last_rd    = (CNT_W'(rd_ptr_q) == (count_q - CNT_W'(1)));

  act_tile_regfile #(
    .TILE_DEPTH (TILE_DEPTH),
    .VEC_W      (VEC_W)
  ) u_regfile (
    .clk     (clk),
    .wr_en   (load_fire),
    .wr_addr (wr_ptr),
    .wr_data (bus.load_data_flat),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = STREAM;
      STREAM:  if (last_rd) state_d = (mode_q || (DRAIN_LEN == 0)) ? DONE : DRAIN;
      DRAIN:   if (drain_q == DRAIN_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      drain_q    <= '0;
      mode_q     <= 1'b0;
      busy_p1    <= 1'b0;
      done_p1    <= 1'b0;
`ifdef ACT_FEEDER_REPLAY_EN
      retained_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      busy_p1 <= (state_q != IDLE);
      done_p1 <= (state_q == DONE);
      unique case (state_q)
        IDLE: begin
          if (load_fire) begin
            count_q    <= count_next;
`ifdef ACT_FEEDER_REPLAY_EN
            retained_q <= 1'b0;
`endif
          end
          if (accept) begin
            mode_q   <= bus.test_mode;
            rd_ptr_q <= '0;
          end
        end
        STREAM: begin
          drain_q <= '0;
          if (!last_rd) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
        DRAIN: drain_q <= drain_q + DRN_W'(1);
        DONE: begin
`ifdef ACT_FEEDER_REPLAY_EN
          retained_q <= 1'b1;
`else
          count_q <= '0;
`endif
        end
        default: ;
      endcase
    end
  end

  // Stage p1: registered vector to the skew buffer, zero whenever not valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      act_p1 <= '0;
    end else begin
      unique case (state_q)
        STREAM: begin
          vld_p1 <= 1'b1;
          act_p1 <= rd_data;
        end
        DRAIN: begin
          vld_p1 <= 1'b1;
          act_p1 <= '0;
        end
        default: begin
          vld_p1 <= 1'b0;
          act_p1 <= '0;
        end
      endcase
    end
  end

  assign bus.load_ready          = load_ready;
  assign bus.activation_out_flat = act_p1;
  assign bus.activation_valid    = vld_p1;
  assign bus.mode_out            = mode_q;
  assign bus.busy                = busy_p1;
  assign bus.done                = done_p1;

endmodule
